// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// refill FSM state encoding and byte-address field extraction helpers.
package icache_pkg;

  localparam int unsigned NLINES_DEF = 32;
  localparam int unsigned WPL_DEF    = 4;
  localparam int unsigned AW_DEF     = 32;

  localparam int unsigned OFFW = $clog2(WPL_DEF);
  localparam int unsigned IDXW = $clog2(NLINES_DEF);
  localparam int unsigned TAGW = AW_DEF - IDXW - OFFW - 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRefill = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Field helpers take the geometry as arguments so any parameterisation can share them.
  function automatic logic [63:0] addr_offset(input logic [63:0] a, input int unsigned offw);
    return (a >> 2) & ((64'd1 << offw) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a, input int unsigned offw,
                                             input int unsigned idxw);
    return (a >> (offw + 2)) & ((64'd1 << idxw) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int unsigned offw,
                                           input int unsigned idxw);
    return a >> (offw + idxw + 2);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling for icache_dm: latches the missing line, walks the refill beats
// over the memory handshake and generates stallF.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned IDXW = 5,
  parameter int unsigned OFFW = 2,
  parameter int unsigned TAGW = AW - IDXW - OFFW - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_hit,
  input  logic [TAGW-1:0] i_tag,
  input  logic [IDXW-1:0] i_idx,
  input  logic            i_rvalid,
  output logic            o_stall,
  output logic            o_mem_req,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_we,
  output logic            o_last,
  output logic            o_idle,
  output logic [OFFW-1:0] o_beat,
  output logic [IDXW-1:0] o_miss_idx,
  output logic [TAGW-1:0] o_miss_tag
);

  state_e          r_state, w_state_d;
  logic [OFFW-1:0] r_beat, w_beat_d;
  logic [TAGW-1:0] r_miss_tag, w_miss_tag_d;
  logic [IDXW-1:0] r_miss_idx, w_miss_idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_beat     <= '0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_beat     <= w_beat_d;
      r_miss_tag <= w_miss_tag_d;
      r_miss_idx <= w_miss_idx_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_beat_d     = r_beat;
    w_miss_tag_d = r_miss_tag;
    w_miss_idx_d = r_miss_idx;
    o_stall      = 1'b1;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_we         = 1'b0;
    o_last       = 1'b0;
    o_idle       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_idle  = 1'b1;
        o_stall = !i_hit;
        if (!i_hit) begin
          w_miss_tag_d = i_tag;
          w_miss_idx_d = i_idx;
          w_beat_d     = '0;
          w_state_d    = StRefill;
        end
      end
      StRefill: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_miss_tag, r_miss_idx, r_beat, 2'b00};
        if (i_rvalid) begin
          o_we = 1'b1;
          // WPL is a power of two, so the last beat is the all-ones offset.
          if (&r_beat) begin
            o_last    = 1'b1;
            w_beat_d  = '0;
            w_state_d = StDone;
          end else begin
            w_beat_d = r_beat + 1'b1;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign o_beat     = r_beat;
  assign o_miss_idx = r_miss_idx;
  assign o_miss_tag = r_miss_tag;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit lookup on pcF,
// line refill from main memory one word per beat on a miss.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned NLINES = NLINES_DEF,
  parameter int unsigned WPL    = WPL_DEF,
  parameter int unsigned AW     = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pcF,
  output logic [31:0]   instrF,
  output logic          stallF,
  input  logic          inv,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned L_OFFW = $clog2(WPL);
  localparam int unsigned L_IDXW = $clog2(NLINES);
  localparam int unsigned L_TAGW = AW - L_IDXW - L_OFFW - 2;

  logic [L_TAGW-1:0] r_tag  [NLINES];
  logic [31:0]       r_data [NLINES*WPL];
  logic [NLINES-1:0] r_valid, w_valid_d;

  logic [L_OFFW-1:0] w_off, w_beat;
  logic [L_IDXW-1:0] w_idx, w_miss_idx;
  logic [L_TAGW-1:0] w_tag, w_miss_tag;
  logic              w_hit, w_we, w_last, w_idle;

  assign w_off = L_OFFW'(addr_offset(64'(pcF), L_OFFW));
  assign w_idx = L_IDXW'(addr_index(64'(pcF), L_OFFW, L_IDXW));
  assign w_tag = L_TAGW'(addr_tag(64'(pcF), L_OFFW, L_IDXW));

  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  icache_refill_fsm #(
    .AW  (AW),
    .IDXW(L_IDXW),
    .OFFW(L_OFFW),
    .TAGW(L_TAGW)
  ) u_refill_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_hit     (w_hit),
    .i_tag     (w_tag),
    .i_idx     (w_idx),
    .i_rvalid  (mem_rvalid),
    .o_stall   (stallF),
    .o_mem_req (mem_req),
    .o_mem_addr(mem_addr),
    .o_we      (w_we),
    .o_last    (w_last),
    .o_idle    (w_idle),
    .o_beat    (w_beat),
    .o_miss_idx(w_miss_idx),
    .o_miss_tag(w_miss_tag)
  );

  // Arrays are deliberately not reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_we) r_data[{w_miss_idx, w_beat}] <= mem_rdata;
    if (w_last) r_tag[w_miss_idx] <= w_miss_tag;
  end

  // Invalidate clears everything, but a completing refill still marks its own line.
  always_comb begin
    w_valid_d = r_valid;
    if (inv) w_valid_d = '0;
    if (w_last) w_valid_d[w_miss_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_valid <= '0;
    else      r_valid <= w_valid_d;
  end

  assign instrF = w_idle ? r_data[{w_idx, w_off}] : 32'h0;

endmodule
